// File: rtl/irq_pkg.sv
// irq_pkg -- shared definitions for the interrupt controller.
//   irq_state_t : request FSM encoding (IDLE, REQ, SERVICE)
//   OFF_*       : register byte offsets from BASE
//   DEF_BASE    : default byte address of the MASK register
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam logic [31:0] OFF_MASK = 32'd0;
    localparam logic [31:0] OFF_PEND = 32'd4;
    localparam logic [31:0] OFF_ID   = 32'd8;
    localparam logic [31:0] DEF_BASE = 32'h4000_0030;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc -- combinational lowest-index priority encoder.
// Ports:
//   req [NSRC-1:0] in  : request vector
//   idx [2:0]      out : lowest set index (0 when none)
//   vld            out : at least one request set
module irq_prio_enc #(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0] req,
    output logic [2:0]      idx,
    output logic            vld
);

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        idx = 3'd0;
        vld = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// irq_controller -- memory-mapped interrupt controller with a single
// outstanding request towards the Control unit.
// Registers (byte addresses): MASK @BASE (RW), PEND @BASE+4 (read, W1C),
// ID @BASE+8 (read-only, mirrors irq_id).
// Macro IRQ_EDGE_DETECT_EN: defined -> PEND set on src 0->1 transitions;
// undefined -> level capture (PEND set every cycle src is high).
// Ports:
//   clk, reset           : clock (rising), async active-low reset
//   src [NSRC-1:0]       : interrupt source lines
//   PC31                 : CPU kernel-mode bit
//   MemRd, MemWr, Addr, WriteData, ReadData : register bus
//   IRQ, irq_id [2:0]    : registered request and source index
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NSRC = 4,
    parameter logic [31:0] BASE = DEF_BASE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            PC31,
    input  logic            MemRd,
    input  logic            MemWr,
    input  logic [31:0]     Addr,
    input  logic [31:0]     WriteData,
    output logic [31:0]     ReadData,
    output logic            IRQ,
    output logic [2:0]      irq_id
);

    irq_state_t      state;
    logic [NSRC-1:0] mask, pend, pend_nx, cap, act;
    logic [2:0]      win_idx;
    logic            win_vld;
    logic            sel_mask, sel_pend, sel_id, accept;
    logic            unused_wd;

    assign sel_mask  = (Addr == BASE + OFF_MASK);
    assign sel_pend  = (Addr == BASE + OFF_PEND);
    assign sel_id    = (Addr == BASE + OFF_ID);
    assign unused_wd = ^WriteData[31:NSRC];

`ifdef IRQ_EDGE_DETECT_EN
    logic [NSRC-1:0] src_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) src_q <= '0;
        else        src_q <= src;
    end

    assign cap = src & ~src_q;
`else
    assign cap = src;
`endif

    assign act = pend & mask;

    irq_prio_enc #(.NSRC(NSRC)) u_prio (
        .req (act),
        .idx (win_idx),
        .vld (win_vld)
    );

    // CPU has entered the handler for the request currently on irq_id.
    assign accept = (state == REQ) && PC31;

    // Clears first (software W1C, then hardware acceptance), capture last
    // so a new arrival on the same edge is never lost.
    always_comb begin
        pend_nx = pend;
        if (MemWr && sel_pend)
            pend_nx = pend_nx & ~WriteData[NSRC-1:0];
        if (accept) begin
            for (int i = 0; i < NSRC; i++)
                if (irq_id == 3'(i)) pend_nx[i] = 1'b0;
        end
        pend_nx = pend_nx | cap;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask <= '0;
            pend <= '0;
        end else begin
            pend <= pend_nx;
            if (MemWr && sel_mask) mask <= WriteData[NSRC-1:0];
        end
    end

    always_comb begin
        ReadData = '0;
        if (MemRd) begin
            if (sel_mask)     ReadData[NSRC-1:0] = mask;
            else if (sel_pend) ReadData[NSRC-1:0] = pend;
            else if (sel_id)   ReadData[2:0]      = irq_id;
        end
    end

    // Request FSM; IRQ and irq_id are registered here. PC31=1 blocks new
    // requests in IDLE, so the CPU never sees one while in kernel mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            IRQ    <= 1'b0;
            irq_id <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld && !PC31) begin
                        state  <= REQ;
                        IRQ    <= 1'b1;
                        irq_id <= win_idx;
                    end
                end
                REQ: begin
                    if (PC31) begin
                        state <= SERVICE;
                        IRQ   <= 1'b0;
                    end else if (!win_vld) begin
                        state <= IDLE;
                        IRQ   <= 1'b0;
                    end else begin
                        irq_id <= win_idx;
                    end
                end
                SERVICE: begin
                    IRQ <= 1'b0;
                    if (!PC31) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    IRQ   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller -- directed self-checking bench for irq_controller.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_irq_controller;

    localparam logic [31:0] B = 32'h4000_0030;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src;
    logic        PC31, MemRd, MemWr;
    logic [31:0] Addr, WriteData, ReadData;
    logic        IRQ;
    logic [2:0]  irq_id;
    logic [31:0] rv;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    irq_controller #(.NSRC(4), .BASE(B)) dut (
        .clk       (clk),
        .reset     (reset),
        .src       (src),
        .PC31      (PC31),
        .MemRd     (MemRd),
        .MemWr     (MemWr),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .IRQ       (IRQ),
        .irq_id    (irq_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWr = 1'b1; Addr = a; WriteData = d;
        tick();
        MemWr = 1'b0; Addr = '0; WriteData = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        MemRd = 1'b1; Addr = a;
        #1;
        d = ReadData;
        MemRd = 1'b0; Addr = '0;
    endtask

    initial begin
        reset = 1'b0; src = '0; PC31 = 1'b0;
        MemRd = 1'b0; MemWr = 1'b0; Addr = '0; WriteData = '0;

        // reset state
        #3;
        chk("rst_irq", 32'(IRQ), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        rd(B, rv); chk("rst_mask", rv, 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // S1: single masked-in pulse, accept, hardware clear
        wr(B, 32'h2);
        wr(B + 8, 32'hFF);
        wr(B + 12, 32'hFF);
        rd(B, rv);      chk("s1_mask", rv, 32'h2);
        rd(B + 12, rv); chk("s1_unmapped_rd", rv, 32'd0);
        Addr = B; #1;   chk("s1_no_rd", ReadData, 32'd0);
        Addr = '0;
        src = 4'b0010;
        tick();
        src = 4'b0000;
        rd(B + 4, rv);  chk("s1_pend", rv, 32'h2);
        chk("s1_irq_early", 32'(IRQ), 32'd0);
        tick();
        chk("s1_irq", 32'(IRQ), 32'd1);
        chk("s1_id", 32'(irq_id), 32'd1);
        PC31 = 1'b1;
        tick();
        chk("s1_irq_acc", 32'(IRQ), 32'd0);
        rd(B + 4, rv);  chk("s1_pend_clr", rv, 32'd0);
        rd(B + 8, rv);  chk("s1_cur", rv, 32'd1);
        PC31 = 1'b0;
        tick(); tick();
        chk("s1_idle", 32'(IRQ), 32'd0);

        // S2: priority and preemption inside REQ
        wr(B, 32'hF);
        src = 4'b1100;
        tick(); tick();
        chk("s2_irq", 32'(IRQ), 32'd1);
        chk("s2_id2", 32'(irq_id), 32'd2);
        src = 4'b1101;
        tick();
        rd(B + 4, rv);  chk("s2_pend", rv, 32'hD);
        tick();
        chk("s2_id0", 32'(irq_id), 32'd0);
        chk("s2_irq_hold", 32'(IRQ), 32'd1);
        src = 4'b0000;
        wr(B, 32'h0);
        tick();
        chk("s2_drop", 32'(IRQ), 32'd0);
        wr(B + 4, 32'hF);

        // S3: masked pending, then unmask, then W1C while in REQ
        src = 4'b0001;
        tick();
        src = 4'b0000;
        tick();
        rd(B + 4, rv);  chk("s3_pend", rv, 32'h1);
        chk("s3_masked", 32'(IRQ), 32'd0);
        wr(B, 32'h1);
        tick();
        chk("s3_irq", 32'(IRQ), 32'd1);
        chk("s3_id", 32'(irq_id), 32'd0);
        wr(B + 4, 32'h1);
        tick();
        chk("s3_w1c_irq", 32'(IRQ), 32'd0);
        rd(B + 4, rv);  chk("s3_w1c_pend", rv, 32'd0);

        // S4: no nesting during SERVICE, request after return
        wr(B, 32'hF);
        src = 4'b0001;
        tick();
        src = 4'b0000;
        tick();
        PC31 = 1'b1;
        tick();
        src = 4'b1000;
        tick();
        src = 4'b0000;
        tick();
        chk("s4_svc_irq", 32'(IRQ), 32'd0);
        rd(B + 4, rv);  chk("s4_pend", rv, 32'h8);
        PC31 = 1'b0;
        tick();
        chk("s4_ret_irq", 32'(IRQ), 32'd0);
        tick();
        chk("s4_irq", 32'(IRQ), 32'd1);
        chk("s4_id", 32'(irq_id), 32'd3);
        PC31 = 1'b1;
        tick();
        PC31 = 1'b0;
        tick();

        // S5: source held high across acceptance
        src = 4'b0010;
        tick(); tick();
        chk("s5_id", 32'(irq_id), 32'd1);
        PC31 = 1'b1;
        tick(); tick();
        chk("s5_irq", 32'(IRQ), 32'd0);
        rd(B + 4, rv);
`ifdef IRQ_EDGE_DETECT_EN
        chk("s5_pend_edge", rv, 32'h0);
`else
        chk("s5_pend_level", rv, 32'h2);
`endif
        src = 4'b0000;
        wr(B + 4, 32'hF);
        PC31 = 1'b0;
        tick();

        // S6: asynchronous reset during SERVICE
        src = 4'b0100;
        tick();
        src = 4'b0000;
        tick();
        PC31 = 1'b1;
        tick();
        src = 4'b1000;
        tick();
        src = 4'b0000;
        chk("s6_pre_id", 32'(irq_id), 32'd2);
        rd(B + 4, rv);  chk("s6_pre_pend", rv, 32'h8);
        #1;
        reset = 1'b0;
        #1;
        chk("s6_irq", 32'(IRQ), 32'd0);
        chk("s6_id", 32'(irq_id), 32'd0);
        rd(B, rv);      chk("s6_mask", rv, 32'd0);
        rd(B + 4, rv);  chk("s6_pend", rv, 32'd0);
        PC31 = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
